// File: rtl/k_alu_result_stage.sv
// Writeback-side stage behind K_ALU: derives status flags at accept time and
// holds up to two results in a small FIFO behind a valid/ready handshake.
module k_alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_z,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_z,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_wen,
  output logic [5:0]        out_flags
);

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_DIV  = 4'b0011;
  localparam logic [3:0] FN_ADD4 = 4'b1101;
  localparam logic [3:0] FN_SUB4 = 4'b1110;
  localparam logic [3:0] FN_ILL  = 4'b1111;

  logic [DATA_W-1:0] r_z     [2];
  logic [TAG_W-1:0]  r_rd    [2];
  logic              r_wen   [2];
  logic [5:0]        r_flags [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_accept;
  logic              w_pop;
  logic [DATA_W-1:0] w_add_wrap;
  logic              w_sa;
  logic              w_sb;
  logic              w_sz;
  logic              w_zero;
  logic              w_carry;
  logic              w_ovf;
  logic              w_dz;
  logic              w_ill;
  logic [5:0]        w_flags;

  assign in_ready  = !rst && (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_z     = r_z[r_rd_ptr];
  assign out_rd    = r_rd[r_rd_ptr];
  assign out_wen   = r_wen[r_rd_ptr];
  assign out_flags = r_flags[r_rd_ptr];

  // Carry-out of a wrapping add shows up as the sum falling below an operand.
  assign w_add_wrap = in_a + in_b;
  assign w_sa   = in_a[DATA_W-1];
  assign w_sb   = in_b[DATA_W-1];
  assign w_sz   = in_z[DATA_W-1];
  assign w_zero = (in_z == '0);
  assign w_dz   = (in_func == FN_DIV) && (in_b == '0);
  assign w_ill  = (in_func == FN_ILL);

  always_comb begin
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (in_func)
      FN_ADD: begin
        w_carry = (w_add_wrap < in_a);
        w_ovf   = (w_sa == w_sb) && (w_sz != w_sa);
      end
      FN_ADD4: begin
        // a + 4 overflows the width exactly when a >= 2^W - 4
        w_carry = &in_a[DATA_W-1:2];
        w_ovf   = !w_sa && w_sz;
      end
      FN_SUB: begin
        w_carry = (in_a < in_b);
        w_ovf   = (w_sa != w_sb) && (w_sz != w_sa);
      end
      FN_SUB4: begin
        w_carry = (in_a < DATA_W'(4));
        w_ovf   = w_sa && !w_sz;
      end
      default: begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  assign w_flags = {w_ill, w_dz, w_ovf, w_carry, w_sz, w_zero};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_z[i]     <= '0;
        r_rd[i]    <= '0;
        r_wen[i]   <= 1'b0;
        r_flags[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_z[r_wr_ptr]     <= in_z;
        r_rd[r_wr_ptr]    <= in_rd;
        r_wen[r_wr_ptr]   <= in_wen && !w_ill;
        r_flags[r_wr_ptr] <= w_flags;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_k_alu_result_stage.sv
// Directed bench for k_alu_result_stage: the driver queues hand-computed
// expectations, an independent monitor pops them as the DUT presents results.
module tb_k_alu_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_z;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [5:0]  out_flags;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  rd;
    logic        wen;
    logic [5:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_pop = 0;

  k_alu_result_stage #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_a(in_a), .in_b(in_b), .in_z(in_z),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_rd(out_rd), .out_wen(out_wen), .out_flags(out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares the head on every pop and checks head stability on stalls.
  exp_t prev_head;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_head", {out_z, out_rd, out_wen, out_flags}, prev_head);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        prev_stall = 1'b0;
        n_pop++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got z=%0h rd=%0d with empty scoreboard", out_z, out_rd);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_z", out_z, e.z);
          chk("out_rd", out_rd, e.rd);
          chk("out_wen", out_wen, e.wen);
          chk("out_flags", out_flags, e.flags);
        end
      end else if (out_valid === 1'b1) begin
        prev_stall = 1'b1;
        prev_head  = {out_z, out_rd, out_wen, out_flags};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fn,
                      input logic [31:0] z, input logic [4:0] rd, input logic wen,
                      input logic [5:0] exp_flags, input logic exp_wen);
    int n;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_func = fn; in_z = z; in_rd = rd; in_wen = wen;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for rd=%0d", rd);
      in_valid = 1'b0;
    end else begin
      sb.push_back({z, rd, exp_wen, exp_flags});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_func = 4'h0; in_a = '0; in_b = '0; in_z = '0; in_rd = '0; in_wen = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_all", {out_z, out_rd, out_wen, out_flags}, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    cycles(1);

    send(32'd34, 32'd3, 4'b0000, 32'd37, 5'd7, 1'b1, 6'b000000, 1'b1);
    chk("latency_valid", out_valid, 1);
    send(32'd3, 32'd34, 4'b0001, 32'hFFFF_FFE1, 5'd2, 1'b1, 6'b000110, 1'b1);
    send(32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 5'd3, 1'b1, 6'b001010, 1'b1);
    send(32'hFFFF_FFFF, 32'd0, 4'b1101, 32'd3, 5'd4, 1'b1, 6'b000100, 1'b1);
    send(32'd34, 32'd0, 4'b0011, 32'h0000_DEAD, 5'd5, 1'b1, 6'b010000, 1'b1);
    send(32'd34, 32'd0, 4'b0011, 32'h0000_DEAD, 5'd6, 1'b0, 6'b010000, 1'b0);
    send(32'd1, 32'd2, 4'b1111, 32'h1234_5678, 5'd8, 1'b1, 6'b100000, 1'b0);
    send(32'd2, 32'd0, 4'b1110, 32'hFFFF_FFFE, 5'd9, 1'b1, 6'b000110, 1'b1);
    send(32'h8000_0000, 32'd0, 4'b1110, 32'h7FFF_FFFC, 5'd10, 1'b1, 6'b001000, 1'b1);
    send(32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 5'd11, 1'b1, 6'b000101, 1'b1);
    send(32'h0000_00F0, 32'h0000_000F, 4'b0010, 32'd0, 5'd12, 1'b1, 6'b000001, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 4'b0000, 32'd0, 5'd13, 1'b1, 6'b001101, 1'b1);
    cycles(3);

    // Backpressure: third result must wait upstream while the head holds.
    out_ready = 1'b0;
    send(32'd1, 32'd1, 4'b0000, 32'd2, 5'd20, 1'b1, 6'b000000, 1'b1);
    send(32'd2, 32'd2, 4'b0000, 32'd4, 5'd21, 1'b1, 6'b000000, 1'b1);
    chk("full_in_ready", in_ready, 0);
    fork
      send(32'd3, 32'd3, 4'b0000, 32'd6, 5'd22, 1'b1, 6'b000000, 1'b1);
      begin
        cycles(4);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_head_rd", out_rd, 20);
        out_ready = 1'b1;
      end
    join
    cycles(4);
    chk("drain_empty", out_valid, 0);

    // Reset while full: nothing old or offered during reset may reappear.
    out_ready = 1'b0;
    send(32'd5, 32'd5, 4'b0000, 32'd10, 5'd24, 1'b1, 6'b000000, 1'b1);
    send(32'd6, 32'd6, 4'b0000, 32'd12, 5'd25, 1'b1, 6'b000000, 1'b1);
    rst = 1'b1;
    in_valid = 1'b1; in_func = 4'h0; in_a = 32'd9; in_b = 32'd9; in_z = 32'd18;
    in_rd = 5'd30; in_wen = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    cycles(1);
    sb.delete();
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_all", {out_z, out_rd, out_wen, out_flags}, 0);
    chk("rst_mid_in_ready2", in_ready, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycles(4);
    chk("post_rst_empty", out_valid, 0);
    send(32'd7, 32'd0, 4'b0000, 32'd7, 5'd26, 1'b1, 6'b000000, 1'b1);
    cycles(4);

    chk("sb_drained", sb.size(), 0);
    chk("pop_count", n_pop, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
